// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: one iterative shift-add multiplier shared by NUM_REQ
// requesters through a round-robin arbiter. One operation is in flight at a time.
//   clk, rst_n     clock, asynchronous active-low reset
//   req_valid      per-requester request valid
//   req_a, req_b   packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready      one-hot accept, asserted only in IDLE
//   resp_valid     product available (DONE state)
//   resp_ready     consumer accepts product
//   resp_id        index of the requester owning resp_product
//   resp_product   unsigned A*B, 2*WIDTH bits
//   busy           high while an operation is in CALC or DONE
module mult_share_ctrl #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]     req_a,
    input  logic [NUM_REQ*WIDTH-1:0]     req_b,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [$clog2(NUM_REQ)-1:0]   resp_id,
    output logic [2*WIDTH-1:0]           resp_product,
    output logic                         busy
);

    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam int unsigned CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned PW  = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [IDW-1:0]   id_q, id_d;

    logic             any_valid;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   idx_w;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;

    // Round-robin search starting at rr_ptr, wrapping mod NUM_REQ
    always_comb begin
        any_valid = 1'b0;
        grant_idx = '0;
        idx_w     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_w = IDW'((32'(rr_ptr_q) + 32'(i)) % NUM_REQ);
            if (!any_valid && req_valid[idx_w]) begin
                any_valid = 1'b1;
                grant_idx = idx_w;
            end
        end
    end

    // Operand mux for the granted requester
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                a_sel = req_a[i*WIDTH +: WIDTH];
                b_sel = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Accept is combinational and suppressed while reset is asserted
    always_comb begin
        req_ready = '0;
        if (rst_n && (state_q == IDLE) && any_valid) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        id_d     = id_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    a_d      = PW'(a_sel);
                    b_d      = b_sel;
                    id_d     = grant_idx;
                    acc_d    = '0;
                    cnt_d    = '0;
                    rr_ptr_d = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);
                    state_d  = CALC;
                end
            end
            CALC: begin
                // Always runs WIDTH steps, even for zero operands
                if (b_q[0]) begin
                    acc_d = acc_q + a_q;
                end
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            id_q     <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            id_q     <= id_d;
        end
    end

    // Response fields come straight from flops; acc is frozen in DONE
    assign resp_valid   = (state_q == DONE);
    assign resp_product = acc_q;
    assign resp_id      = id_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl: table of single operations plus a
// hand-written mid-operation reset sequence.
module tb_mult_share_ctrl;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned WIDTH   = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ready;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_id;
    logic [15:0] resp_product;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    mult_share_ctrl #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_id      (resp_id),
        .resp_product (resp_product),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  exp_ready;
        logic [1:0]  exp_id;
        logic [15:0] exp_prod;
        int          stall;
        bit          chk_interval;
    } vec_t;

    vec_t vecs[14];
    vec_t v_post;
    time  last_accept;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Called at a negedge with the DUT in IDLE; returns at a negedge back in IDLE
    task automatic run_vec(input int k, input vec_t v);
        int   n;
        bit   stray;
        bit   unstable;
        time  t;
        req_valid  = v.valid;
        req_a      = v.a;
        req_b      = v.b;
        resp_ready = (v.stall == 0);
        #1;
        check($sformatf("v%0d req_ready", k), 32'(req_ready), 32'(v.exp_ready));
        check($sformatf("v%0d busy_idle", k), 32'(busy), 32'd0);
        @(posedge clk);
        t = $time;
        if (v.chk_interval)
            check($sformatf("v%0d interval", k), 32'((t - last_accept) / 10), 32'd10);
        last_accept = t;
        @(negedge clk);
        // Operands after accept must not matter
        req_a = ~v.a;
        req_b = ~v.b;
        n = 0;
        stray = 1'b0;
        while (!resp_valid && n < 20) begin
            if (req_ready != 4'b0 || !busy) stray = 1'b1;
            n++;
            @(negedge clk);
        end
        check($sformatf("v%0d latency", k), 32'(n), 32'(WIDTH));
        check($sformatf("v%0d calc_ready_busy", k), 32'(stray), 32'd0);
        check($sformatf("v%0d product", k), 32'(resp_product), 32'(v.exp_prod));
        check($sformatf("v%0d id", k), 32'(resp_id), 32'(v.exp_id));
        if (v.stall > 0) begin
            unstable = 1'b0;
            for (int s = 0; s < v.stall; s++) begin
                @(negedge clk);
                if (!resp_valid || resp_product !== v.exp_prod || resp_id !== v.exp_id
                    || req_ready != 4'b0 || !busy)
                    unstable = 1'b1;
            end
            check($sformatf("v%0d stall_stable", k), 32'(unstable), 32'd0);
            resp_ready = 1'b1;
        end
        @(negedge clk);
        check($sformatf("v%0d idle_after", k), 32'({resp_valid, busy}), 32'd0);
    endtask

    initial begin
        //            valid    A (3..0)                        B (3..0)                        ready    id     prod      stall intv
        vecs[0]  = '{4'b1111, {8'd40, 8'd30, 8'd20, 8'd10}, {8'd5, 8'd4, 8'd3, 8'd2},     4'b0001, 2'd0, 16'd20,    0, 0};
        vecs[1]  = '{4'b1111, {8'd40, 8'd30, 8'd20, 8'd10}, {8'd5, 8'd4, 8'd3, 8'd2},     4'b0010, 2'd1, 16'd60,    0, 1};
        vecs[2]  = '{4'b1111, {8'd40, 8'd30, 8'd20, 8'd10}, {8'd5, 8'd4, 8'd3, 8'd2},     4'b0100, 2'd2, 16'd120,   0, 1};
        vecs[3]  = '{4'b1111, {8'd40, 8'd30, 8'd20, 8'd10}, {8'd5, 8'd4, 8'd3, 8'd2},     4'b1000, 2'd3, 16'd200,   0, 1};
        vecs[4]  = '{4'b1111, {8'd40, 8'd30, 8'd20, 8'd10}, {8'd5, 8'd4, 8'd3, 8'd2},     4'b0001, 2'd0, 16'd20,    0, 1};
        vecs[5]  = '{4'b0010, {8'd0, 8'd0, 8'd3, 8'd0},     {8'd0, 8'd0, 8'd5, 8'd0},     4'b0010, 2'd1, 16'd15,    0, 0};
        vecs[6]  = '{4'b0001, {8'd0, 8'd0, 8'd0, 8'd255},   {8'd0, 8'd0, 8'd0, 8'd255},   4'b0001, 2'd0, 16'hFE01,  5, 0};
        vecs[7]  = '{4'b0001, {8'd0, 8'd0, 8'd0, 8'd0},     {8'd0, 8'd0, 8'd0, 8'd200},   4'b0001, 2'd0, 16'd0,     0, 0};
        vecs[8]  = '{4'b1000, {8'd7, 8'd0, 8'd0, 8'd0},     {8'd9, 8'd0, 8'd0, 8'd0},     4'b1000, 2'd3, 16'd63,    0, 0};
        vecs[9]  = '{4'b1001, {8'd13, 8'd0, 8'd0, 8'd12},   {8'd14, 8'd0, 8'd0, 8'd11},   4'b0001, 2'd0, 16'd132,   0, 0};
        vecs[10] = '{4'b1001, {8'd13, 8'd0, 8'd0, 8'd12},   {8'd14, 8'd0, 8'd0, 8'd11},   4'b1000, 2'd3, 16'd182,   2, 0};
        vecs[11] = '{4'b0110, {8'd0, 8'd1, 8'd255, 8'd0},   {8'd0, 8'd255, 8'd1, 8'd0},   4'b0010, 2'd1, 16'd255,   0, 0};
        vecs[12] = '{4'b0110, {8'd0, 8'd1, 8'd255, 8'd0},   {8'd0, 8'd255, 8'd1, 8'd0},   4'b0100, 2'd2, 16'd255,   0, 1};
        vecs[13] = '{4'b0100, {8'd0, 8'd128, 8'd0, 8'd0},   {8'd0, 8'd2, 8'd0, 8'd0},     4'b0100, 2'd2, 16'd256,   0, 0};
        v_post   = '{4'b1100, {8'd0, 8'd6, 8'd0, 8'd0},     {8'd0, 8'd7, 8'd0, 8'd0},     4'b0100, 2'd2, 16'd42,    0, 0};

        last_accept = 0;
        rst_n      = 1'b0;
        req_valid  = 4'b1111;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'({req_ready, resp_valid, resp_id, resp_product, busy}), 32'd0);
        req_valid = 4'b0000;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("idle_no_req", 32'({req_ready, busy}), 32'd0);

        for (int k = 0; k < 14; k++) run_vec(k, vecs[k]);

        // Reset partway through CALC: rr_ptr is 3 here, so requester 0 wins
        req_valid  = 4'b0001;
        req_a      = 32'd9;
        req_b      = 32'd9;
        resp_ready = 1'b1;
        #1;
        check("pre_reset_grant", 32'(req_ready), 32'b0001);
        @(posedge clk);
        repeat (4) @(posedge clk);
        @(negedge clk);
        req_valid = 4'b1100;
        rst_n = 1'b0;
        #1;
        check("midop_reset_outputs", 32'({req_ready, resp_valid, resp_id, resp_product, busy}), 32'd0);
        repeat (3) @(negedge clk);
        check("reset_held_outputs", 32'({req_ready, resp_valid, busy}), 32'd0);
        rst_n = 1'b1;
        run_vec(99, v_post);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time bound so the bench always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
